// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-map datapath blocks.
package cnn_pkg;

    localparam int OUT_WIDTH = 8;
    localparam int MAP_SIZE  = 16;
    localparam int IDX_W     = $clog2(MAP_SIZE);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/relu_map_streamer_if.sv
// Pixel stream bus: one activation pixel per beat with its map position.
interface relu_map_streamer_if #(
    parameter int OUT_WIDTH = cnn_pkg::OUT_WIDTH,
    parameter int IDX_W     = cnn_pkg::IDX_W
);
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]     m_row;
    logic [IDX_W-1:0]     m_col;
    logic                 m_eol;
    logic                 m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_eol, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_eol, m_last,
        output m_ready
    );
endinterface

// File: rtl/map_pos_counter.sv
// Row-major position counter over a MAP_SIZE x MAP_SIZE map.
// clr_i has priority over en_i; the counter wraps to (0,0) after the last pixel.
module map_pos_counter #(
    parameter int MAP_SIZE = cnn_pkg::MAP_SIZE,
    parameter int IDX_W    = $clog2(MAP_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             eol_o,
    output logic             last_o
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAP_SIZE - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    // Next position: advance column, carry into row at end of line.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == MAX_IDX) begin
                col_d = '0;
                row_d = (row_q == MAX_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign eol_o  = (col_q == MAX_IDX);
    assign last_o = (col_q == MAX_IDX) && (row_q == MAX_IDX);
endmodule

// File: rtl/relu_map_streamer.sv
// Captures a whole post-ReLU map in one load and streams it pixel by pixel.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no map held for output; in_ready=1, waiting for a load
//   ST_STREAM | emitting captured map row-major; m_valid=1 every cycle
module relu_map_streamer
    import cnn_pkg::*;
#(
    parameter int OUT_WIDTH = cnn_pkg::OUT_WIDTH,
    parameter int MAP_SIZE  = cnn_pkg::MAP_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [OUT_WIDTH*MAP_SIZE*MAP_SIZE-1:0] ifm,
    input  logic                                 flush,
    output logic                                 busy,
    relu_map_streamer_if.master                  m
);
    localparam int RW = $clog2(MAP_SIZE);

    state_t state_q, state_d;
    logic [OUT_WIDTH*MAP_SIZE*MAP_SIZE-1:0] cap_q;

    logic [RW-1:0] row, col;
    logic          eol, last;
    logic          streaming, beat, last_beat, load, cnt_clr;
    int            pix_idx;

    assign streaming = (state_q == ST_STREAM);
    assign beat      = streaming && m.m_ready;
    assign last_beat = beat && last;

    // A flush in the same cycle as the final beat ends the map outright, so
    // the early reload window is closed in that case.
    assign in_ready  = !streaming || (last_beat && !flush);
    assign load      = in_valid && in_ready;
    assign cnt_clr   = load || last_beat || (streaming && flush);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (flush)          state_d = ST_IDLE;
                else if (last_beat) state_d = load ? ST_STREAM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture register: the stream reads only this copy, never ifm directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cap_q <= '0;
        else if (load) cap_q <= ifm;
    end

    map_pos_counter #(.MAP_SIZE(MAP_SIZE), .IDX_W(RW)) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (beat),
        .row_o  (row),
        .col_o  (col),
        .eol_o  (eol),
        .last_o (last)
    );

    assign pix_idx = int'(row) * MAP_SIZE + int'(col);

    assign m.m_valid = streaming;
    assign m.m_data  = streaming ? cap_q[pix_idx*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign m.m_row   = row;
    assign m.m_col   = col;
    assign m.m_eol   = eol;
    assign m.m_last  = last;
    assign busy      = streaming;
endmodule

// File: tb/tb_relu_map_streamer.sv
module tb_relu_map_streamer;
    localparam int W  = 8;
    localparam int N  = 16;
    localparam int NP = N * N;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W*NP-1:0] ifm;
    logic            flush;
    logic            busy;

    relu_map_streamer_if #(.OUT_WIDTH(W), .IDX_W(4)) sif ();

    relu_map_streamer #(.OUT_WIDTH(W), .MAP_SIZE(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ifm      (ifm),
        .flush    (flush),
        .busy     (busy),
        .m        (sif.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] map_a [NP];
    logic [7:0] map_b [NP];

    int obs_d [0:NP+15];
    int obs_r [0:NP+15];
    int obs_c [0:NP+15];
    int obs_e [0:NP+15];
    int obs_l [0:NP+15];

    function automatic logic [W*NP-1:0] pack(input logic [7:0] mp [NP]);
        logic [W*NP-1:0] f;
        f = '0;
        for (int p = 0; p < NP; p++) f[p*W +: W] = mp[p];
        return f;
    endfunction

    // Offer a map and hold in_valid until one edge with in_ready high.
    // Entry/exit time: 1 time unit after a rising edge.
    task automatic load_map(input logic [W*NP-1:0] f, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        ifm = f;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Record accepted beats until an accepted m_last beat; flags stall changes.
    task automatic collect(input bit rand_ready, input int budget,
                           output int n, output int stall_err, output bit timeout);
        bit held;
        int hd, hr, hc, he, hl;
        bit lb;
        n = 0; stall_err = 0; timeout = 1'b1; held = 1'b0;
        hd = 0; hr = 0; hc = 0; he = 0; hl = 0;
        for (int c = 0; c < budget; c++) begin
            sif.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held && (int'(sif.m_data) != hd || int'(sif.m_row) != hr ||
                         int'(sif.m_col) != hc || int'(sif.m_eol) != he ||
                         int'(sif.m_last) != hl || !sif.m_valid))
                stall_err++;
            held = sif.m_valid && !sif.m_ready;
            hd = sif.m_data; hr = sif.m_row; hc = sif.m_col;
            he = sif.m_eol;  hl = sif.m_last;
            lb = 1'b0;
            if (sif.m_valid && sif.m_ready && n <= NP + 15) begin
                obs_d[n] = sif.m_data; obs_r[n] = sif.m_row; obs_c[n] = sif.m_col;
                obs_e[n] = sif.m_eol;  obs_l[n] = sif.m_last;
                lb = sif.m_last;
                n++;
            end
            @(posedge clk); #1;
            if (lb) begin timeout = 1'b0; break; end
        end
        sif.m_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; ifm = '1; flush = 1'b0; sif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || sif.m_valid !== 1'b0 || sif.m_data !== 8'h00 ||
            sif.m_row !== 4'd0 || sif.m_col !== 4'd0 || sif.m_eol !== 1'b0 ||
            sif.m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b valid=%b data=%h row=%0d col=%0d eol=%b last=%b required all 0",
                     busy, sif.m_valid, sif.m_data, sif.m_row, sif.m_col, sif.m_eol, sif.m_last);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic check_stream(input string nm, input logic [7:0] mp [NP],
                                input int n, input bit timeout);
        total++;
        if (timeout || n != NP) begin
            bad++;
            $display("FAIL %s_count: beats=%0d timeout=%0b required %0d 0", nm, n, timeout, NP);
        end
        for (int k = 0; k < NP && k < n; k++) begin
            total++;
            if (obs_d[k] != int'(mp[k]) || obs_r[k] != k / N || obs_c[k] != k % N ||
                obs_e[k] != int'(k % N == N - 1) || obs_l[k] != int'(k == NP - 1)) begin
                bad++;
                $display("FAIL %s_beat%0d: data=%0d row=%0d col=%0d eol=%0d last=%0d required %0d %0d %0d %0d %0d",
                         nm, k, obs_d[k], obs_r[k], obs_c[k], obs_e[k], obs_l[k],
                         mp[k], k / N, k % N, int'(k % N == N - 1), int'(k == NP - 1));
            end
        end
    endtask

    task automatic test_linear;
        bit ok, to; int n, se;
        for (int p = 0; p < NP; p++) map_a[p] = 8'(p);
        load_map(pack(map_a), ok);
        total++;
        if (!ok || sif.m_valid !== 1'b1 || sif.m_data !== 8'h00) begin
            bad++;
            $display("FAIL linear_first: ok=%0b valid=%b data=%h required 1 1 00", ok, sif.m_valid, sif.m_data);
        end
        collect(1'b0, 400, n, se, to);
        check_stream("linear", map_a, n, to);
        total++;
        if (busy !== 1'b0 || sif.m_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL linear_after: busy=%b valid=%b in_ready=%b required 0 0 1", busy, sif.m_valid, in_ready);
        end
    endtask

    task automatic test_random_ready;
        bit ok, to; int n, se;
        load_map(pack(map_a), ok);
        collect(1'b1, 4000, n, se, to);
        check_stream("randrdy", map_a, n, to);
        total++;
        if (se != 0) begin
            bad++;
            $display("FAIL randrdy_stall: changes=%0d required 0", se);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, to; int n, se;
        for (int p = 0; p < NP; p++) map_b[p] = 8'(p) ^ 8'hFF;
        load_map(pack(map_a), ok);
        in_valid = 1'b1;
        ifm = pack(map_b);
        collect(1'b0, 400, n, se, to);
        in_valid = 1'b0;
        check_stream("b2b_first", map_a, n, to);
        total++;
        if (sif.m_valid !== 1'b1 || sif.m_data !== 8'hFF || sif.m_row !== 4'd0 || sif.m_col !== 4'd0) begin
            bad++;
            $display("FAIL b2b_gap: valid=%b data=%h row=%0d col=%0d required 1 ff 0 0",
                     sif.m_valid, sif.m_data, sif.m_row, sif.m_col);
        end
        collect(1'b0, 400, n, se, to);
        check_stream("b2b_second", map_b, n, to);
    endtask

    task automatic test_capture_isolation;
        bit ok, to; int n, se;
        for (int p = 0; p < NP; p++) map_b[p] = 8'($urandom);
        load_map(pack(map_b), ok);
        ifm = {NP{8'hAA}};
        collect(1'b1, 4000, n, se, to);
        check_stream("isolate", map_b, n, to);
    endtask

    task automatic test_flush;
        bit ok, to, saw_last; int n, se;
        for (int p = 0; p < NP; p++) map_a[p] = 8'($urandom);
        load_map(pack(map_a), ok);
        sif.m_ready = 1'b1;
        saw_last = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (sif.m_last) saw_last = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (sif.m_data !== map_a[100] || sif.m_row !== 4'd6 || sif.m_col !== 4'd4) begin
            bad++;
            $display("FAIL flush_pre: data=%h row=%0d col=%0d required %h 6 4",
                     sif.m_data, sif.m_row, sif.m_col, map_a[100]);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sif.m_ready = 1'b0;
        #1;
        total++;
        if (sif.m_valid !== 1'b0 || busy !== 1'b0 || sif.m_last !== 1'b0 || saw_last ||
            sif.m_row !== 4'd0 || sif.m_col !== 4'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_post: valid=%b busy=%b last=%b saw_last=%0b row=%0d col=%0d in_ready=%b required 0 0 0 0 0 0 1",
                     sif.m_valid, busy, sif.m_last, saw_last, sif.m_row, sif.m_col, in_ready);
        end
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) map_b[p] = 8'($urandom);
        load_map(pack(map_b), ok);
        collect(1'b0, 400, n, se, to);
        check_stream("flush_reload", map_b, n, to);
    endtask

    task automatic test_reset_midstream;
        bit ok;
        for (int p = 0; p < NP; p++) map_a[p] = 8'($urandom) | 8'h01;
        load_map(pack(map_a), ok);
        sif.m_ready = 1'b1;
        repeat (37) begin @(posedge clk); #1; end
        total++;
        if (sif.m_data !== map_a[37] || sif.m_row !== 4'd2 || sif.m_col !== 4'd5) begin
            bad++;
            $display("FAIL rstmid_pre: data=%h row=%0d col=%0d required %h 2 5",
                     sif.m_data, sif.m_row, sif.m_col, map_a[37]);
        end
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || sif.m_valid !== 1'b0 || sif.m_data !== 8'h00 ||
            sif.m_row !== 4'd0 || sif.m_col !== 4'd0 || sif.m_eol !== 1'b0 || sif.m_last !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: busy=%b valid=%b data=%h row=%0d col=%0d eol=%b last=%b required all 0",
                     busy, sif.m_valid, sif.m_data, sif.m_row, sif.m_col, sif.m_eol, sif.m_last);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || sif.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ignore_load: busy=%b valid=%b required 0 0", busy, sif.m_valid);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || sif.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_release: in_ready=%b valid=%b required 1 0", in_ready, sif.m_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_random_ready();
        test_back_to_back();
        test_capture_isolation();
        test_flush();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
